// File: rtl/pl_hazard_ctrl_pkg.sv
// pl_defs_pkg: shared opcodes, controller state encodings and register-address fields
package pl_defs_pkg;

    localparam logic [4:0] OP_RLOAD  = 5'b01000;
    localparam logic [4:0] OP_RSTORE = 5'b01001;
    localparam logic [4:0] OP_RECNST = 5'b10110;

    // bit of a 4-bit operand address that selects the RNS register domain
    localparam int DOM_BIT = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pl_hazard_ctrl_if.sv
// pl_hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs of the sequencing controller
interface pl_hazard_ctrl_if #(parameter int PROG_CTR_WID = 10);

    logic [4:0]              opcode_ID;
    logic [3:0]              op1_addr_ID;
    logic [3:0]              op2_addr_ID;
    logic [2:0]              op3_addr_ID;
    logic                    load_in_EX;
    logic [2:0]              load_dst_EX;
    logic                    branch_taken_EX;
    logic [PROG_CTR_WID-1:0] branch_target_EX;
    logic [PROG_CTR_WID-1:0] pc_IF;
    logic                    stall_pc;
    logic                    stall_IFID;
    logic                    hold_IDEX;
    logic                    bubble_IDEX;
    logic                    flush_IFID;
    logic                    mc_busy;
    logic                    mc_done;
    logic [1:0]              ctrl_state;

    modport master (
        output opcode_ID, op1_addr_ID, op2_addr_ID, op3_addr_ID,
        output load_in_EX, load_dst_EX, branch_taken_EX, branch_target_EX,
        input  pc_IF, stall_pc, stall_IFID, hold_IDEX, bubble_IDEX,
        input  flush_IFID, mc_busy, mc_done, ctrl_state
    );

    modport slave (
        input  opcode_ID, op1_addr_ID, op2_addr_ID, op3_addr_ID,
        input  load_in_EX, load_dst_EX, branch_taken_EX, branch_target_EX,
        output pc_IF, stall_pc, stall_IFID, hold_IDEX, bubble_IDEX,
        output flush_IFID, mc_busy, mc_done, ctrl_state
    );

endinterface

// File: rtl/pl_hazard_ctrl_ld_haz.sv
// pl_ld_haz_detect: flags an ID instruction that reads the integer register an RLOAD in EX is writing
module pl_ld_haz_detect
    import pl_defs_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [3:0] op1_addr,
    input  logic [3:0] op2_addr,
    input  logic [2:0] op3_addr,
    input  logic       load_in,
    input  logic [2:0] load_dst,
    output logic       ld_haz
);

    // RNS-domain operands live in a different register file, so only integer reads can collide
    assign ld_haz = load_in &&
                    ((!op1_addr[DOM_BIT] && op1_addr[2:0] == load_dst) ||
                     (!op2_addr[DOM_BIT] && op2_addr[2:0] == load_dst) ||
                     (opcode == OP_RSTORE && op3_addr == load_dst));

endmodule

// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl: PC owner and stall/bubble/flush sequencer for branches, load-use and multi-cycle RECNST
module pl_hazard_ctrl
    import pl_defs_pkg::*;
#(
    parameter int PROG_CTR_WID  = 10,
    parameter int RECNST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pl_hazard_ctrl_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(RECNST_CYCLES - 2);

    ctrl_state_t             state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [PROG_CTR_WID-1:0] pc, pc_nxt;
    logic                    busy, busy_nxt;
    logic                    ld_haz;
    logic                    stall_pc, stall_ifid, hold_idex, bubble_idex, flush_ifid, mc_done;

    pl_ld_haz_detect u_ld_haz (
        .opcode   (bus.opcode_ID),
        .op1_addr (bus.op1_addr_ID),
        .op2_addr (bus.op2_addr_ID),
        .op3_addr (bus.op3_addr_ID),
        .load_in  (bus.load_in_EX),
        .load_dst (bus.load_dst_EX),
        .ld_haz   (ld_haz)
    );

    // next state, PC, RECNST countdown and pipeline controls; branch beats ld_haz beats RECNST start
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        busy_nxt    = busy;
        pc_nxt      = pc + 1'b1;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        hold_idex   = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        mc_done     = 1'b0;
        case (state)
            ST_RUN: begin
                if (bus.branch_taken_EX) begin
                    pc_nxt      = bus.branch_target_EX;
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    state_nxt   = ST_FLUSH;
                end else if (ld_haz) begin
                    pc_nxt      = pc;
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end else if (bus.opcode_ID == OP_RECNST) begin
                    cnt_nxt   = CNT_INIT;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_MC_BUSY;
                end
            end
            ST_MC_BUSY: begin
                if (bus.branch_taken_EX) begin
                    // illegal while RECNST owns EX, but a redirect must never be lost
                    pc_nxt      = bus.branch_target_EX;
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    cnt_nxt     = '0;
                    busy_nxt    = 1'b0;
                    state_nxt   = ST_FLUSH;
                end else begin
                    pc_nxt     = pc;
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    hold_idex  = 1'b1;
                    cnt_nxt    = cnt - 4'd1;
                    if (cnt == '0) begin
                        mc_done   = 1'b1;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                // ID holds a squashed instruction, so hazards and RECNST decode are meaningless here
                flush_ifid = 1'b1;
                if (bus.branch_taken_EX) begin
                    pc_nxt      = bus.branch_target_EX;
                    bubble_idex = 1'b1;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
        endcase
        if (rst) begin
            stall_pc    = 1'b0;
            stall_ifid  = 1'b0;
            hold_idex   = 1'b0;
            bubble_idex = 1'b0;
            flush_ifid  = 1'b0;
            mc_done     = 1'b0;
        end
    end

    // state, PC, counter and busy flag; reset takes effect immediately, even mid-RECNST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
            pc    <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pc    <= pc_nxt;
            busy  <= busy_nxt;
        end
    end

    assign bus.pc_IF       = pc;
    assign bus.stall_pc    = stall_pc;
    assign bus.stall_IFID  = stall_ifid;
    assign bus.hold_IDEX   = hold_idex;
    assign bus.bubble_IDEX = bubble_idex;
    assign bus.flush_IFID  = flush_ifid;
    assign bus.mc_busy     = busy;
    assign bus.mc_done     = mc_done;
    assign bus.ctrl_state  = state;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// tb_pl_hazard_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_pl_hazard_ctrl;

    typedef struct packed {
        logic [9:0] pc;
        logic [6:0] ctl;
        logic [1:0] st;
    } exp_t;

    localparam logic [4:0] NOP = 5'b00000;
    localparam logic [4:0] RST = 5'b01001;
    localparam logic [4:0] REC = 5'b10110;
    localparam logic [3:0] RNS = 4'b1000;

    logic   clk;
    logic   rst;
    exp_t   exp_q[$];
    string  nm_q[$];
    int     checks = 0;
    int     failures = 0;

    pl_hazard_ctrl_if #(.PROG_CTR_WID(10)) bus();

    pl_hazard_ctrl #(.PROG_CTR_WID(10), .RECNST_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // ctl = {stall_pc, stall_IFID, hold_IDEX, bubble_IDEX, flush_IFID, mc_busy, mc_done}
    task automatic cyc(input string nm, input logic [4:0] op, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [2:0] a3, input logic ld, input logic [2:0] ldd, input logic br,
                       input logic [9:0] tgt, input logic [9:0] epc, input logic [6:0] ectl, input logic [1:0] est);
        bus.opcode_ID        = op;
        bus.op1_addr_ID      = a1;
        bus.op2_addr_ID      = a2;
        bus.op3_addr_ID      = a3;
        bus.load_in_EX       = ld;
        bus.load_dst_EX      = ldd;
        bus.branch_taken_EX  = br;
        bus.branch_target_EX = tgt;
        exp_q.push_back('{pc: epc, ctl: ectl, st: est});
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [9:0] epc, input logic [6:0] ectl, input logic [1:0] est);
        cyc(nm, NOP, RNS, RNS, 3'd0, 1'b0, 3'd0, 1'b0, 10'd0, epc, ectl, est);
    endtask

    // pops one expectation per cycle and compares it with what the DUT is presenting
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            g = '{pc: bus.pc_IF,
                  ctl: {bus.stall_pc, bus.stall_IFID, bus.hold_IDEX, bus.bubble_IDEX,
                        bus.flush_IFID, bus.mc_busy, bus.mc_done},
                  st: bus.ctrl_state};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s: got pc=%0d ctl=%b st=%0d, expected pc=%0d ctl=%b st=%0d",
                         n, g.pc, g.ctl, g.st, e.pc, e.ctl, e.st);
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle("reset", 10'd0, 7'b0000000, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) idle("straight", 10'(i), 7'b0000000, 2'd0);
        cyc("ld_haz_op1",   NOP, 4'b0011, RNS, 3'd0, 1'b1, 3'd3, 1'b0, 10'd0, 10'd6, 7'b1101000, 2'd0);
        cyc("ld_rns_op1",   NOP, 4'b1011, RNS, 3'd0, 1'b1, 3'd3, 1'b0, 10'd0, 10'd6, 7'b0000000, 2'd0);
        cyc("ld_haz_rstor", RST, RNS, RNS, 3'd2, 1'b1, 3'd2, 1'b0, 10'd0, 10'd7, 7'b1101000, 2'd0);
        cyc("ld_haz_op2",   NOP, RNS, 4'b0101, 3'd0, 1'b1, 3'd5, 1'b0, 10'd0, 10'd7, 7'b1101000, 2'd0);
        cyc("no_load",      NOP, 4'b0011, RNS, 3'd0, 1'b0, 3'd3, 1'b0, 10'd0, 10'd7, 7'b0000000, 2'd0);
        cyc("recnst_start", REC, RNS, RNS, 3'd0, 1'b0, 3'd0, 1'b0, 10'd0, 10'd8, 7'b0000000, 2'd0);
        idle("mc_1", 10'd9, 7'b1110010, 2'd1);
        idle("mc_2", 10'd9, 7'b1110010, 2'd1);
        idle("mc_3_done", 10'd9, 7'b1110011, 2'd1);
        idle("mc_resume", 10'd9, 7'b0000000, 2'd0);
        cyc("ldhaz_over_rec", REC, 4'b0001, RNS, 3'd0, 1'b1, 3'd1, 1'b0, 10'd0, 10'd10, 7'b1101000, 2'd0);
        cyc("recnst_start2",  REC, RNS, RNS, 3'd0, 1'b0, 3'd0, 1'b0, 10'd0, 10'd10, 7'b0000000, 2'd0);
        idle("mc2_1", 10'd11, 7'b1110010, 2'd1);
        bus.opcode_ID = NOP;
        #2;
        rst = 1'b1;
        exp_q.push_back('{pc: 10'd0, ctl: 7'b0000000, st: 2'd0});
        nm_q.push_back("rst_mid_mc");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("after_rst", 10'd0, 7'b0000000, 2'd0);
        cyc("br_priority", REC, 4'b0011, RNS, 3'd0, 1'b1, 3'd3, 1'b1, 10'h2A, 10'd1, 7'b0001100, 2'd0);
        cyc("flush_ignore", REC, 4'b0011, RNS, 3'd0, 1'b1, 3'd3, 1'b0, 10'd0, 10'h2A, 7'b0000100, 2'd2);
        idle("post_flush", 10'h2B, 7'b0000000, 2'd0);
        cyc("br_to_1022", NOP, RNS, RNS, 3'd0, 1'b0, 3'd0, 1'b1, 10'd1022, 10'h2C, 7'b0001100, 2'd0);
        cyc("br_in_flush", NOP, RNS, RNS, 3'd0, 1'b0, 3'd0, 1'b1, 10'd1021, 10'd1022, 7'b0001100, 2'd2);
        idle("flush_1021", 10'd1021, 7'b0000100, 2'd2);
        idle("pc_1022", 10'd1022, 7'b0000000, 2'd0);
        idle("pc_1023", 10'd1023, 7'b0000000, 2'd0);
        idle("pc_wrap", 10'd0, 7'b0000000, 2'd0);
        cyc("recnst_start3", REC, RNS, RNS, 3'd0, 1'b0, 3'd0, 1'b0, 10'd0, 10'd1, 7'b0000000, 2'd0);
        cyc("br_in_mc", NOP, RNS, RNS, 3'd0, 1'b0, 3'd0, 1'b1, 10'h100, 10'd2, 7'b0001110, 2'd1);
        idle("flush_abort", 10'h100, 7'b0000100, 2'd2);
        idle("run_abort", 10'h101, 7'b0000000, 2'd0);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pl_hazard_ctrl.md
Name: pl_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 8-bit RISC/RNS core.
- Owns the program counter and drives the hold, bubble and flush controls for the IF/ID and ID/EX pipeline registers.
- Resolves three events: taken-branch redirect, load-use hazards, and the multi-cycle RNS reconstruction op (RECNST, opcode 5'b10110), which occupies EX for RECNST_CYCLES cycles.

Parameters:
- PROG_CTR_WID, 10, program counter / instruction address width.
- RECNST_CYCLES, 4, EX occupancy of RECNST in cycles; legal range 2..16.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode_ID  in  5  opcode of the instruction currently in ID.
- op1_addr_ID  in  4  rs1 address in ID; [3] = domain flag (1 = RNS).
- op2_addr_ID  in  4  rs2 address in ID; [3] = domain flag.
- op3_addr_ID  in  3  RSTORE source register address in ID (integer domain).
- load_in_EX  in  1  instruction in EX is RLOAD and is not invalidated.
- load_dst_EX  in  3  destination register of that RLOAD.
- branch_taken_EX  in  1  branch resolved taken in EX.
- branch_target_EX  in  PROG_CTR_WID  branch target address.
- pc_IF  out  PROG_CTR_WID  fetch address to instruction memory (registered).
- stall_pc  out  1  PC must not advance this cycle.
- stall_IFID  out  1  IF/ID register holds its contents.
- hold_IDEX  out  1  ID/EX register holds its contents (EX is busy).
- bubble_IDEX  out  1  ID/EX loads a NOP.
- flush_IFID  out  1  IF/ID loads an invalidated instruction.
- mc_busy  out  1  RECNST in progress (registered).
- mc_done  out  1  one-cycle pulse in the final RECNST EX cycle.
- ctrl_state  out  2  FSM state for debug: RUN=0, MC_BUSY=1, FLUSH=2.

Behaviour:
- Reset (asynchronous, immediate): pc_IF=0, state=RUN, counter=0, mc_busy=0.
- Combinational outputs during reset: all 0.
- Registered: pc_IF, state, 4-bit counter, mc_busy. All other outputs are combinational from state and current inputs, effective at the next edge.
- Load-use hazard (ld_haz) is true when load_in_EX is set and any of the following holds:
  - op1_addr_ID[3]==0 and op1_addr_ID[2:0]==load_dst_EX;
  - op2_addr_ID[3]==0 and op2_addr_ID[2:0]==load_dst_EX;
  - opcode_ID==RSTORE (5'b01001) and op3_addr_ID==load_dst_EX.
- Priority in every state: branch > ld_haz > RECNST start.

RUN state:
- branch_taken_EX: pc<=branch_target_EX, flush_IFID=1, bubble_IDEX=1, next state FLUSH.
- Else ld_haz: stall_pc=1, stall_IFID=1, bubble_IDEX=1, stay in RUN. Exactly one bubble, because the load leaves EX on the next cycle.
- Else opcode_ID==RECNST: the instruction advances normally into EX, pc<=pc+1, counter<=RECNST_CYCLES-2, mc_busy<=1, next state MC_BUSY.
- Else: pc<=pc+1, wrapping from 2^PROG_CTR_WID-1 to 0.

MC_BUSY state:
- Outputs: stall_pc=1, stall_IFID=1, hold_IDEX=1, mc_busy=1.
- The counter decrements each cycle.
- When counter==0: mc_done=1, hold_IDEX=1 for this final cycle, next state RUN with mc_busy<=0. Total EX occupancy is RECNST_CYCLES cycles.
- branch_taken_EX while in MC_BUSY is a protocol violation, because EX holds RECNST. It is still honoured: abort, pc<=target, flush, counter<=0, mc_busy<=0, next state FLUSH.

FLUSH state:
- flush_IFID=1 and stall_pc=0; the PC advances from the target.
- Next state RUN.
- A branch during FLUSH reloads pc<=target and the state remains FLUSH.

General rules:
- ld_haz and RECNST are ignored in FLUSH, because the ID instruction is invalid.
- Reset asserted mid-RECNST returns to RUN immediately with counter=0.

Decomposition:
- Shared package pl_defs_pkg:
  - opcode localparams OP_RLOAD, OP_RSTORE, OP_RECNST;
  - state encodings ST_RUN, ST_MC_BUSY, ST_FLUSH;
  - domain-flag bit index.
- One natural sub-module, pl_ld_haz_detect: purely combinational ld_haz comparator.
- The FSM, counter and PC logic stay in the top module.

Test Plan:
- Straight-line execution: from reset with no events for 5 cycles -> pc_IF = 0,1,2,3,4,5; all stall/flush outputs 0. Preload pc near 1023 -> wraps 1023 -> 0.
- Load-use hazard: load_in_EX=1, load_dst_EX=3, op1_addr_ID=4'b0011 -> stall_pc=stall_IFID=bubble_IDEX=1 for 1 cycle, pc held. Repeat with op1_addr_ID=4'b1011 (RNS domain) -> no stall.
- RSTORE hazard: opcode_ID=5'b01001, op3_addr_ID=2, load_dst_EX=2 -> one bubble cycle.
- RECNST: opcode_ID=5'b10110 with RECNST_CYCLES=4 -> MC_BUSY for 3 cycles with hold_IDEX=1; mc_done pulses in the 3rd cycle; pc frozen throughout; RUN resumes afterwards.
- Branch priority: branch_taken_EX=1, target=0x2A, simultaneous with ld_haz and RECNST in ID -> pc_IF=0x2A, flush_IFID=1, bubble_IDEX=1, state FLUSH then RUN; no MC entry.
- Reset mid-RECNST: assert rst asynchronously in the 2nd MC_BUSY cycle -> immediately pc_IF=0, ctrl_state=0, mc_busy=0.
